// File: rtl/clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator (clken_gen).
package clken_pkg;

    localparam int CH_IDX_W  = 4;
    // Pending-slot payload width; the generator's ACC_W must not exceed this.
    localparam int CFG_W_MAX = 32;

    typedef struct packed {
        logic [CH_IDX_W-1:0]  ch;
        logic [CFG_W_MAX-1:0] num;
        logic [CFG_W_MAX-1:0] den;
    } clken_cfg_t;

    // Low bit of field idx inside a packed per-channel parameter vector.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/clken_ch.sv
// One rational phase-accumulator channel: emits a registered single-cycle enable
// at rate num/den of the steps it is given, with a load port for new ratios.
module clken_ch
    import clken_pkg::*;
#(
    parameter int               ACC_W   = 16,
    parameter logic [ACC_W-1:0] NUM_RST = '0,
    parameter logic [ACC_W-1:0] DEN_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             load,
    input  logic [ACC_W-1:0] load_num,
    input  logic [ACC_W-1:0] load_den,
    output logic             ce,
    output logic             wrap,
    output logic             idle
);

    logic [ACC_W-1:0] num_q;
    logic [ACC_W-1:0] den_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] num_eff;
    logic [ACC_W-1:0] diff;
    logic [ACC_W:0]   sum;

    // A numerator at or above the denominator saturates to one pulse per step.
    always_comb begin
        num_eff = (num_q >= den_q) ? den_q : num_q;
        sum     = {1'b0, acc_q} + {1'b0, num_eff};
        diff    = ACC_W'(sum - {1'b0, den_q});
        idle    = (den_q == '0) || (num_q == '0);
        wrap    = step && (den_q != '0) && (sum >= {1'b0, den_q});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= NUM_RST;
            den_q <= DEN_RST;
            acc_q <= '0;
            ce    <= 1'b0;
        end else begin
            if (!step || den_q == '0) begin
                acc_q <= '0;
                ce    <= 1'b0;
            end else if (wrap) begin
                acc_q <= diff;
                ce    <= 1'b1;
            end else begin
                acc_q <= sum[ACC_W-1:0];
                ce    <= 1'b0;
            end
            // A new ratio restarts the phase from zero.
            if (load) begin
                num_q <= load_num;
                den_q <= load_den;
                acc_q <= '0;
            end
        end
    end

endmodule

// File: rtl/clken_gen.sv
// Multi-channel fractional clock-enable generator with a PLL-style lock indication.
// Runtime ratio reprogramming is built only when CLKEN_RECFG_EN is defined.
module clken_gen
    import clken_pkg::*;
#(
    parameter int                      NUM_CH   = 3,
    parameter int                      ACC_W    = 16,
    parameter logic [NUM_CH*ACC_W-1:0] NUM_INIT = {16'd1, 16'd1, 16'd2},
    parameter logic [NUM_CH*ACC_W-1:0] DEN_INIT = {16'd25, 16'd2, 16'd5},
    parameter int                      LOCK_CYC = 1024
) (
    input  logic                refclk,
    input  logic                rst,
    output logic [NUM_CH-1:0]   ce,
    output logic                locked,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_num,
    input  logic [ACC_W-1:0]    cfg_den
);

    localparam int CNT_W = $clog2(LOCK_CYC + 1);

    logic [CNT_W-1:0]  cnt_q;
    logic              locked_q;
    logic              lock_rise;
    logic              step;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] idle;
    logic [NUM_CH-1:0] load;
    logic [ACC_W-1:0]  load_num;
    logic [ACC_W-1:0]  load_den;

    // Channels take their first step on the same edge that raises locked.
    assign lock_rise = !locked_q && (cnt_q == CNT_W'(LOCK_CYC - 1));
    assign step      = locked_q || lock_rise;
    assign locked    = locked_q;

    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else if (!locked_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (lock_rise) begin
                locked_q <= 1'b1;
            end
        end
    end

`ifdef CLKEN_RECFG_EN
    // cfg handshake: a request transfers on any edge where cfg_valid and cfg_ready
    // are both high; cfg_ready is low until locked and while the slot is occupied.
    clken_cfg_t pend_q;
    logic       pend_valid_q;
    logic       unused_pend;

    assign cfg_ready   = locked_q && !pend_valid_q;
    assign load_num    = pend_q.num[ACC_W-1:0];
    assign load_den    = pend_q.den[ACC_W-1:0];
    assign unused_pend = ^{pend_q.num, pend_q.den};

    always_ff @(posedge refclk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else if (pend_valid_q) begin
            if (|load) begin
                pend_valid_q <= 1'b0;
            end
        end else if (cfg_valid && cfg_ready && (32'(cfg_ch) < 32'(NUM_CH))) begin
            pend_valid_q <= 1'b1;
            pend_q       <= '{ch: cfg_ch, num: CFG_W_MAX'(cfg_num), den: CFG_W_MAX'(cfg_den)};
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_load
        assign load[i] = pend_valid_q && (pend_q.ch == CH_IDX_W'(i)) && (wrap[i] || idle[i]);
    end
`else
    logic unused_cfg;

    assign cfg_ready  = 1'b0;
    assign load       = '0;
    assign load_num   = '0;
    assign load_den   = '0;
    assign unused_cfg = ^{cfg_valid, cfg_ch, cfg_num, cfg_den, wrap, idle};
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clken_ch #(
            .ACC_W   (ACC_W),
            .NUM_RST (NUM_INIT[slice_lo(i, ACC_W) +: ACC_W]),
            .DEN_RST (DEN_INIT[slice_lo(i, ACC_W) +: ACC_W])
        ) u_ch (
            .clk      (refclk),
            .rst      (rst),
            .step     (step),
            .load     (load[i]),
            .load_num (load_num),
            .load_den (load_den),
            .ce       (ce[i]),
            .wrap     (wrap[i]),
            .idle     (idle[i])
        );
    end

endmodule
